// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB3 requester slice.
//   - apb_state_e   : transfer FSM states (IDLE, SETUP, ACCESS, DONE)
//   - apb_decode_t  : result of the address decode {hit, idx}
//   - APB_REGION_BASE / SLAVE_WINDOW_* : address map of the peripheral region
//   - cnt_width()   : width of a counter that must hold 0..limit-1
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   // Peripheral region lives at addr[31:16] == APB_REGION_BASE and each slave
   // owns one 4 KiB window selected by addr[15:12].
   localparam logic [15:0] APB_REGION_BASE   = 16'h1000;
   localparam int          SLAVE_WINDOW_BITS = 4;
   localparam int          SLAVE_WINDOW_LSB  = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                         hit;
      logic [SLAVE_WINDOW_BITS-1:0] idx;
   } apb_decode_t;

   // Width of a counter that only ever holds 0..limit-1; never below one bit
   // so a limit of 1 still yields a legal vector.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/apb_decoder.sv
// -----------------------------------------------------------------------------
// apb_decoder
// Combinational address decoder for the APB peripheral region.
//   addr : byte address presented by the CPU
//   dec  : {hit, idx}; hit=1 when the address falls in the region and the
//          window index addr[15:12] names an existing slave (< NUM_SLAVES)
// -----------------------------------------------------------------------------
module apb_decoder
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 4
) (
   input  logic [ADDR_W-1:0] addr,
   output apb_decode_t       dec
);

   // One extra bit so NUM_SLAVES=16 is representable and the compare is
   // always true for a full window.
   localparam logic [SLAVE_WINDOW_BITS:0] SLAVE_LIMIT = NUM_SLAVES[SLAVE_WINDOW_BITS:0];

   logic [SLAVE_WINDOW_BITS-1:0] window;
   logic                         in_region;
   logic                         unused_addr_bits;

   assign window    = addr[SLAVE_WINDOW_LSB +: SLAVE_WINDOW_BITS];
   assign in_region = (addr[ADDR_W-1:16] == APB_REGION_BASE);

   assign dec.hit = in_region && ({1'b0, window} < SLAVE_LIMIT);
   assign dec.idx = window;

   // Offset inside a slave window does not take part in the decode.
   assign unused_addr_bits = ^addr[SLAVE_WINDOW_LSB-1:0];

endmodule

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Single-outstanding APB3 requester. Converts one CPU load/store at a time into
// an APB SETUP/ACCESS transfer, selects the slave from the address, muxes the
// selected slave's PRDATA/PREADY back and aborts an ACCESS phase that sees no
// PREADY within TIMEOUT cycles.
//
// Parameters
//   NUM_SLAVES : decoded slaves, 1..16
//   TIMEOUT    : ACCESS cycles without PREADY before abort, 1..65535
// CPU side
//   transfer, write, addr, wdata : request, sampled only in IDLE
//   rdata, ready, err            : registered completion (ready is a 1-cycle pulse)
//   busy                         : high whenever a transfer is in flight
// APB side
//   PADDR, PWDATA, PWRITE        : latched request, held until the next accept
//   PSEL, PENABLE                : one-hot select / ACCESS flag
//   PRDATA_S, PREADY_S           : per-slave read data (32 bits each) and ready
// Clock PCLK, reset PRESET (asynchronous, active-high).
// -----------------------------------------------------------------------------
module apb_master
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                         PCLK,
   input  logic                         PRESET,
   input  logic                         transfer,
   input  logic                         write,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W-1:0]            wdata,
   output logic [DATA_W-1:0]            rdata,
   output logic                         ready,
   output logic                         err,
   output logic                         busy,
   output logic [ADDR_W-1:0]            PADDR,
   output logic [DATA_W-1:0]            PWDATA,
   output logic                         PWRITE,
   output logic [NUM_SLAVES-1:0]        PSEL,
   output logic                         PENABLE,
   input  logic [DATA_W*NUM_SLAVES-1:0] PRDATA_S,
   input  logic [NUM_SLAVES-1:0]        PREADY_S
);

   localparam int               CNT_W    = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   apb_state_e                   state;
   apb_decode_t                  req_dec;
   logic [SLAVE_WINDOW_BITS-1:0] sel_idx;
   logic [CNT_W-1:0]             wait_cnt;
   logic [DATA_W-1:0]            sel_prdata;
   logic                         sel_pready;
   logic                         phase_active;

   // ---------------------------------------------------------------------------
   // Address decode of the incoming request; only consulted in IDLE.
   // ---------------------------------------------------------------------------
   apb_decoder #(
      .NUM_SLAVES (NUM_SLAVES)
   ) u_decoder (
      .addr (addr),
      .dec  (req_dec)
   );

   // ---------------------------------------------------------------------------
   // Return-path mux: only the latched slave's PRDATA/PREADY are ever seen, so
   // stray PREADY from other slaves cannot complete the transfer.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      sel_prdata = '0;
      sel_pready = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (sel_idx == SLAVE_WINDOW_BITS'(k)) begin
            sel_prdata = PRDATA_S[k*DATA_W +: DATA_W];
            sel_pready = PREADY_S[k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // APB control decoded from registered state and the latched slave index.
   // ---------------------------------------------------------------------------
   assign phase_active = (state == SETUP) || (state == ACCESS);
   assign PENABLE      = (state == ACCESS);
   assign busy         = (state != IDLE);

   always_comb begin
      PSEL = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         PSEL[k] = phase_active && (sel_idx == SLAVE_WINDOW_BITS'(k));
      end
   end

   // ---------------------------------------------------------------------------
   // Transfer FSM with registered completion outputs.
   //   IDLE   : accept request, latch it, unmapped goes straight to DONE
   //   SETUP  : one cycle with PSEL only
   //   ACCESS : wait for PREADY or timeout
   //   DONE   : ready pulse, back to IDLE
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state    <= IDLE;
         sel_idx  <= '0;
         wait_cnt <= '0;
         PADDR    <= '0;
         PWDATA   <= '0;
         PWRITE   <= 1'b0;
         rdata    <= '0;
         ready    <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (transfer) begin
                  PADDR    <= addr;
                  PWDATA   <= wdata;
                  PWRITE   <= write;
                  sel_idx  <= req_dec.idx;
                  wait_cnt <= '0;
                  if (req_dec.hit) begin
                     state <= SETUP;
                  end else begin
                     // Nothing to talk to: complete immediately with an error.
                     state <= DONE;
                     ready <= 1'b1;
                     err   <= 1'b1;
                     rdata <= '0;
                  end
               end
            end

            SETUP: begin
               // PREADY is deliberately not looked at in SETUP.
               state    <= ACCESS;
               wait_cnt <= '0;
            end

            ACCESS: begin
               if (sel_pready) begin
                  if (!PWRITE) begin
                     rdata <= sel_prdata;
                  end
                  err   <= 1'b0;
                  ready <= 1'b1;
                  state <= DONE;
               end else if (wait_cnt == CNT_LAST) begin
                  // TIMEOUT ACCESS cycles without PREADY: abandon the slave.
                  err   <= 1'b1;
                  rdata <= '0;
                  ready <= 1'b1;
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            DONE: begin
               // A request presented here is dropped; the CPU waits for ready.
               ready <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master (NUM_SLAVES=4, TIMEOUT=8). Slaves are
// modelled by a per-slave wait count (ACCESS cycles before PREADY) or a stuck
// flag; unselected slaves and the selected slave outside ACCESS drive random
// PREADY. Expected results come from the transfer rules: latency, error, read
// data and select pattern per request.
// -----------------------------------------------------------------------------
module tb_apb_master;

   localparam int NS = 4;
   localparam int TO = 8;

   logic              PCLK     = 1'b0;
   logic              PRESET   = 1'b1;
   logic              transfer = 1'b0;
   logic              write    = 1'b0;
   logic [31:0]       addr     = '0;
   logic [31:0]       wdata    = '0;
   logic [31:0]       rdata;
   logic              ready;
   logic              err;
   logic              busy;
   logic [31:0]       PADDR;
   logic [31:0]       PWDATA;
   logic              PWRITE;
   logic [NS-1:0]     PSEL;
   logic              PENABLE;
   logic [32*NS-1:0]  PRDATA_S;
   logic [NS-1:0]     PREADY_S;

   int tests = 0;
   int fails = 0;

   // Slave models
   logic [31:0]   slv_data [NS];
   int            slv_wait [NS];
   bit            slv_stuck = 1'b0;
   logic [NS-1:0] noise     = '0;
   int            acc_cnt   = 0;
   int            cyc       = 0;

   // Reference state: rdata is held between completions.
   logic [31:0]   exp_rdata = '0;
   int            last_setup_cyc = 0;

   apb_master #(
      .NUM_SLAVES (NS),
      .TIMEOUT    (TO)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .err      (err),
      .busy     (busy),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA_S (PRDATA_S),
      .PREADY_S (PREADY_S)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) begin
      acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
      cyc     <= cyc + 1;
   end

   always @(negedge PCLK) noise <= NS'($urandom);

   always_comb begin
      PRDATA_S = '0;
      PREADY_S = '0;
      for (int k = 0; k < NS; k++) begin
         PRDATA_S[k*32 +: 32] = slv_data[k];
         if (PSEL[k] && PENABLE) PREADY_S[k] = !slv_stuck && (acc_cnt == slv_wait[k]);
         else                    PREADY_S[k] = noise[k];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One request, issued at a negedge while the DUT is IDLE. While busy the
   // bench keeps throwing junk requests that must be ignored.
   task automatic run_xfer(input string name, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input int wt, input bit stuck,
                           input logic [31:0] sd);
      bit            mapped;
      int            idx;
      int            exp_lat;
      bit            exp_err;
      logic [NS-1:0] exp_psel;
      logic [31:0]   exp_rd;
      int            lat;
      logic          obs_err;
      logic [31:0]   obs_rd;
      logic [NS-1:0] psel_seen;

      idx      = int'(a[15:12]);
      mapped   = (a[31:16] == 16'h1000) && (idx < NS);
      exp_err  = !mapped || stuck;
      exp_lat  = !mapped ? 1 : (stuck ? 2 + TO : 3 + wt);
      exp_psel = mapped ? (NS'(1) << idx) : '0;

      for (int k = 0; k < NS; k++) begin
         slv_data[k] = $urandom;
         slv_wait[k] = $urandom_range(0, 3);
      end
      if (mapped) begin
         slv_data[idx] = sd;
         slv_wait[idx] = wt;
      end
      slv_stuck = stuck;

      if (exp_err)  exp_rd = '0;
      else if (wr)  exp_rd = exp_rdata;
      else          exp_rd = sd;

      write    = wr;
      addr     = a;
      wdata    = d;
      transfer = 1'b1;

      lat       = -1;
      obs_err   = 1'b0;
      obs_rd    = '0;
      psel_seen = '0;
      for (int c = 1; c <= TO + 12 && lat < 0; c++) begin
         @(posedge PCLK);
         @(negedge PCLK);
         if (c == 1) begin
            check({name, " busy"},   32'(busy), 32'd1);
            check({name, " PADDR"},  PADDR, a);
            check({name, " PWDATA"}, PWDATA, d);
            check({name, " PWRITE"}, 32'(PWRITE), 32'(wr));
            if (mapped) begin
               check({name, " setup PSEL"},    32'(PSEL), 32'(exp_psel));
               check({name, " setup PENABLE"}, 32'(PENABLE), 32'd0);
               last_setup_cyc = cyc;
            end
         end
         psel_seen |= PSEL;
         if (ready) begin
            lat     = c;
            obs_err = err;
            obs_rd  = rdata;
            check({name, " PSEL in DONE"}, 32'(PSEL), 32'd0);
         end
         transfer = 1'($urandom_range(0, 1));
         write    = 1'($urandom_range(0, 1));
         addr     = $urandom;
         wdata    = $urandom;
      end

      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " err"},     32'(obs_err), 32'(exp_err));
      check({name, " rdata"},   obs_rd, exp_rd);
      check({name, " PSEL set"}, 32'(psel_seen), 32'(exp_psel));

      @(posedge PCLK);
      @(negedge PCLK);
      check({name, " ready pulse"}, 32'(ready), 32'd0);
      check({name, " idle busy"},   32'(busy), 32'd0);
      check({name, " PADDR hold"},  PADDR, a);
      transfer = 1'b0;
      exp_rdata = exp_rd;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          first_setup;
      bit          ready_seen;
      logic [31:0] ra;

      for (int k = 0; k < NS; k++) begin
         slv_data[k] = '0;
         slv_wait[k] = 0;
      end

      // Reset values
      repeat (3) @(negedge PCLK);
      check("reset PSEL",    32'(PSEL), 32'd0);
      check("reset PENABLE", 32'(PENABLE), 32'd0);
      check("reset busy",    32'(busy), 32'd0);
      check("reset ready",   32'(ready), 32'd0);
      check("reset err",     32'(err), 32'd0);
      check("reset rdata",   rdata, 32'd0);
      check("reset PADDR",   PADDR, 32'd0);
      check("reset PWDATA",  PWDATA, 32'd0);
      check("reset PWRITE",  32'(PWRITE), 32'd0);
      PRESET = 1'b0;
      @(negedge PCLK);

      // Directed cases
      run_xfer("wr s2 reg", 1'b1, 32'h1000_2008, 32'h41, 1, 1'b0, 32'hdead_0002);
      run_xfer("rd s1 w3",  1'b0, 32'h1000_100C, 32'h0,  3, 1'b0, 32'h0000_005A);
      run_xfer("rd unmap",  1'b0, 32'h2000_0000, 32'h0,  0, 1'b0, 32'h0);
      run_xfer("rd idx5",   1'b0, 32'h1000_5000, 32'h0,  0, 1'b0, 32'h0);
      run_xfer("rd s3 to",  1'b0, 32'h1000_3010, 32'h0,  0, 1'b1, 32'h0);
      run_xfer("rd s0 after to", 1'b0, 32'h1000_0004, 32'h0, 0, 1'b0, 32'hcafe_f00d);
      run_xfer("b2b wr s0", 1'b1, 32'h1000_0000, 32'h1111_0000, 0, 1'b0, 32'h0);
      first_setup = last_setup_cyc;
      run_xfer("b2b wr s1", 1'b1, 32'h1000_1000, 32'h2222_1111, 0, 1'b0, 32'h0);
      check("b2b setup spacing", 32'(last_setup_cyc - first_setup), 32'd4);

      // Reset during ACCESS
      slv_wait[2] = 6;
      slv_stuck   = 1'b0;
      write       = 1'b0;
      addr        = 32'h1000_2004;
      transfer    = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      transfer = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      check("pre-reset PENABLE", 32'(PENABLE), 32'd1);
      PRESET = 1'b1;
      #1;
      check("midrst PSEL",    32'(PSEL), 32'd0);
      check("midrst PENABLE", 32'(PENABLE), 32'd0);
      check("midrst busy",    32'(busy), 32'd0);
      check("midrst PADDR",   PADDR, 32'd0);
      check("midrst rdata",   rdata, 32'd0);
      @(negedge PCLK);
      PRESET    = 1'b0;
      exp_rdata = '0;
      ready_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge PCLK);
         if (ready) ready_seen = 1'b1;
      end
      check("no ready after reset", 32'(ready_seen), 32'd0);
      run_xfer("rd s2 after rst", 1'b0, 32'h1000_2004, 32'h0, 0, 1'b0, 32'h0bad_beef);

      // Randomised requests against the transfer rules
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0:       ra = $urandom;
            1:       ra = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
            default: ra = {16'h1000, 4'($urandom_range(0, NS - 1)), 12'($urandom)};
         endcase
         run_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), ra, $urandom,
                  $urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
